// File: rtl/camo_key_pkg.sv
// camo_key_pkg: shared FSM states, error codes and select width for the camouflage key loader
package camo_key_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, CHECK} state_t;
  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_PARITY  = 3'd1;
  localparam logic [2:0] ERR_ILLEGAL = 3'd2;
  localparam logic [2:0] ERR_LOCKED  = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam int SEL_W = 2;
endpackage

// File: rtl/camo_key_allow_check.sv
// camo_key_allow_check: flags cells whose 2-bit select code is not allowed by ALLOW_MASK
module camo_key_allow_check
  import camo_key_pkg::*;
#(
  parameter int NUM_CELLS = 6,
  parameter logic [4*NUM_CELLS-1:0] ALLOW_MASK = {NUM_CELLS{4'b1111}}
) (
  input  logic [SEL_W*NUM_CELLS-1:0] key,
  output logic                       all_legal,
  output logic [NUM_CELLS-1:0]       illegal
);
  for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
    wire logic [3:0] m = ALLOW_MASK[4*i +: 4];
    assign illegal[i] = ~m[key[SEL_W*i +: SEL_W]];
  end
  assign all_legal = ~|illegal;
endmodule

// File: rtl/camo_key_loader.sv
// camo_key_loader: serial key frame receiver with parity/legality checks, atomic commit and one-time lock
module camo_key_loader
  import camo_key_pkg::*;
#(
  parameter int NUM_CELLS = 6,
  parameter logic [4*NUM_CELLS-1:0] ALLOW_MASK = {NUM_CELLS{4'b1111}},
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_req,
  input  logic                     abort,
  input  logic                     lock_req,
  input  logic                     key_in_valid,
  input  logic                     key_in_bit,
  output logic                     key_in_ready,
  output logic [2*NUM_CELLS-1:0]   s_key,
  output logic                     key_valid,
  output logic                     busy,
  output logic                     err,
  output logic [2:0]               err_code,
  output logic                     locked
);
  localparam int KEY_W = 2*NUM_CELLS;
  localparam int CNT_W = $clog2(KEY_W);
  localparam int TMO_W = $clog2(TIMEOUT+1);
  state_t state;
  logic [KEY_W-1:0] shadow;
  logic [CNT_W-1:0] cnt;
  logic [TMO_W-1:0] tmo;
  logic parity, all_legal, hs, lock_now;
  logic [NUM_CELLS-1:0] illegal;
  camo_key_allow_check #(.NUM_CELLS(NUM_CELLS), .ALLOW_MASK(ALLOW_MASK)) u_allow (
    .key(shadow), .all_legal(all_legal), .illegal(illegal)
  );
  assign key_in_ready = (state == SHIFT) || (state == PAR);
  assign busy = state != IDLE;
  assign hs = key_in_valid && key_in_ready;
  // a lock honoured this cycle already rejects a same-cycle load
  assign lock_now = lock_req && key_valid;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shadow <= '0;
      cnt <= '0;
      tmo <= '0;
      parity <= 1'b0;
      s_key <= '0;
      key_valid <= 1'b0;
      err <= 1'b0;
      err_code <= ERR_NONE;
      locked <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lock_now) locked <= 1'b1;
          if (load_req && (locked || lock_now)) begin
            err <= 1'b1;
            err_code <= ERR_LOCKED;
          end else if (load_req) begin
            state <= SHIFT;
            err <= 1'b0;
            err_code <= ERR_NONE;
            cnt <= '0;
            shadow <= '0;
            parity <= 1'b0;
            tmo <= '0;
          end
        end
        SHIFT, PAR: begin
          if (abort) begin
            state <= IDLE;
          end else if (hs) begin
            tmo <= '0;
            if (state == SHIFT) begin
              shadow[cnt] <= key_in_bit;
              cnt <= cnt + 1'b1;
              parity <= parity ^ key_in_bit;
              if (cnt == CNT_W'(KEY_W-1)) state <= PAR;
            end else if (parity ^ key_in_bit) begin
              state <= IDLE;
              err <= 1'b1;
              err_code <= ERR_PARITY;
            end else begin
              state <= CHECK;
            end
          end else if (tmo == TMO_W'(TIMEOUT-1)) begin
            state <= IDLE;
            err <= 1'b1;
            err_code <= ERR_TIMEOUT;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        CHECK: begin
          state <= IDLE;
          if (all_legal && !(|illegal)) begin
            s_key <= shadow;
            key_valid <= 1'b1;
          end else begin
            err <= 1'b1;
            err_code <= ERR_ILLEGAL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_camo_key_loader.sv
// tb_camo_key_loader: directed checks of framing, errors, timeout, abort and lock on two parameterisations
module tb_camo_key_loader;
  logic clk = 1'b0;
  logic rst, load_req, abort, lock_req, key_in_valid, key_in_bit;
  logic a_ready, a_kv, a_busy, a_err, a_locked, b_ready, b_kv, b_busy, b_err, b_locked;
  logic [11:0] a_key, b_key;
  logic [2:0] a_code, b_code;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  camo_key_loader dut_a (
    .clk(clk), .rst(rst), .load_req(load_req), .abort(abort), .lock_req(lock_req),
    .key_in_valid(key_in_valid), .key_in_bit(key_in_bit), .key_in_ready(a_ready),
    .s_key(a_key), .key_valid(a_kv), .busy(a_busy), .err(a_err), .err_code(a_code), .locked(a_locked)
  );
  camo_key_loader #(.NUM_CELLS(6), .ALLOW_MASK(24'hFFFFF7), .TIMEOUT(16)) dut_b (
    .clk(clk), .rst(rst), .load_req(load_req), .abort(abort), .lock_req(lock_req),
    .key_in_valid(key_in_valid), .key_in_bit(key_in_bit), .key_in_ready(b_ready),
    .s_key(b_key), .key_valid(b_kv), .busy(b_busy), .err(b_err), .err_code(b_code), .locked(b_locked)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic send_bit(input logic b);
    key_in_valid = 1'b1;
    key_in_bit = b;
    cyc();
    key_in_valid = 1'b0;
  endtask
  task automatic load();
    load_req = 1'b1;
    cyc();
    load_req = 1'b0;
  endtask
  task automatic frame(input logic [11:0] k, input logic p);
    load();
    for (int i = 0; i < 12; i++) send_bit(k[i]);
    send_bit(p);
  endtask
  initial begin
    {load_req, abort, lock_req, key_in_valid, key_in_bit} = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_key", a_key, 0);
    check("rst_kv", a_kv, 0);
    check("rst_busy", a_busy, 0);
    check("rst_err", a_err, 0);
    check("rst_code", a_code, 0);
    check("rst_locked", a_locked, 0);
    check("rst_ready", a_ready, 0);
    rst = 1'b0;
    cyc();
    lock_req = 1'b1;
    cyc();
    lock_req = 1'b0;
    check("lock_no_key", a_locked, 0);
    check("lock_no_key_err", a_err, 0);
    frame(12'hA5C, 1'b1);
    check("par_err", a_err, 1);
    check("par_code", a_code, 1);
    check("par_key", a_key, 0);
    check("par_kv", a_kv, 0);
    check("par_busy", a_busy, 0);
    frame(12'hA5C, 1'b0);
    check("chk_cycle_kv", a_kv, 0);
    check("chk_cycle_busy", a_busy, 1);
    check("chk_cycle_ready", a_ready, 0);
    cyc();
    check("ok_key", a_key, 12'hA5C);
    check("ok_kv", a_kv, 1);
    check("ok_err", a_err, 0);
    check("ok_busy", a_busy, 0);
    check("ok_key_b", b_key, 12'hA5C);
    frame(12'h003, 1'b0);
    cyc();
    check("legal_key_a", a_key, 12'h003);
    check("illegal_code_b", b_code, 2);
    check("illegal_err_b", b_err, 1);
    check("illegal_key_b", b_key, 12'hA5C);
    check("illegal_kv_b", b_kv, 1);
    load();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    repeat (15) cyc();
    check("tmo_pre_busy_b", b_busy, 1);
    cyc();
    check("tmo_code_b", b_code, 4);
    check("tmo_err_b", b_err, 1);
    check("tmo_busy_b", b_busy, 0);
    check("tmo_ready_b", b_ready, 0);
    check("tmo_key_b", b_key, 12'hA5C);
    check("no_tmo_busy_a", a_busy, 1);
    check("no_tmo_code_a", a_code, 0);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("abort_busy_a", a_busy, 0);
    check("abort_err_a", a_err, 0);
    load();
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    abort = 1'b1;
    key_in_valid = 1'b1;
    key_in_bit = 1'b1;
    cyc();
    abort = 1'b0;
    key_in_valid = 1'b0;
    check("abort7_busy", a_busy, 0);
    check("abort7_err", a_err, 0);
    check("abort7_code", a_code, 0);
    check("abort7_key", a_key, 12'h003);
    frame(12'h3FF, 1'b0);
    cyc();
    check("after_abort_key", a_key, 12'h3FF);
    check("after_abort_kv", a_kv, 1);
    check("after_abort_err", a_err, 0);
    check("cell0_illegal_b", b_code, 2);
    frame(12'hA5C, 1'b0);
    cyc();
    check("relock_key", a_key, 12'hA5C);
    lock_req = 1'b1;
    cyc();
    lock_req = 1'b0;
    check("locked", a_locked, 1);
    load();
    check("locked_err", a_err, 1);
    check("locked_code", a_code, 3);
    check("locked_busy", a_busy, 0);
    for (int i = 0; i < 12; i++) send_bit(i % 4 == 0);
    send_bit(1'b1);
    cyc();
    check("locked_key", a_key, 12'hA5C);
    check("locked_ready", a_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rst2_key", a_key, 0);
    check("rst2_kv", a_kv, 0);
    check("rst2_err", a_err, 0);
    check("rst2_code", a_code, 0);
    check("rst2_locked", a_locked, 0);
    check("rst2_busy", a_busy, 0);
    rst = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
